// File: rtl/ycbcr_block_buffer.sv
// Ping-pong block buffer between the RGB-to-YCbCr converter and the 2-D DCT.
// Each incoming {Cr,Cb,Y} pixel is level shifted by -128 and stored in the
// current write bank. Completed 64-pixel blocks are streamed to the DCT under a
// valid/ready handshake while the other bank keeps filling.
module ycbcr_block_buffer #(
  parameter int BLOCK_PIXELS = 64,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [23:0]      data_in,
  output logic             in_ready,
  output logic             overflow,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [23:0]      data_out,
  output logic             block_start,
  output logic             block_end,
  output logic [CNT_W-1:0] block_count
);

  localparam int               PTR_W    = $clog2(BLOCK_PIXELS);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BLOCK_PIXELS - 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  // XOR with 0x80 per component is the same as subtracting 128 in 8-bit two's complement.
  localparam logic [23:0]      LVL_SHIFT = 24'h808080;

  typedef enum logic {
    RD_IDLE,
    RD_STREAM
  } rd_state_e;

  logic [23:0]      mem [2][BLOCK_PIXELS];
  logic [1:0]       full_q;
  logic [1:0]       full_d;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             wr_bank;
  logic             rd_bank;
  rd_state_e        state_q;
  rd_state_e        state_d;

  logic             wr_fire;
  logic             wr_last;
  logic             rd_fire;
  logic             rd_last;
  logic             rd_bank_ready;
  logic             other_bank_ready;

  // Handshake qualifiers and output decode, all from registered state.
  always_comb begin
    in_ready    = !full_q[wr_bank];
    out_valid   = (state_q == RD_STREAM);
    data_out    = out_valid ? mem[rd_bank][rd_ptr] : '0;
    block_start = out_valid && (rd_ptr == '0);
    block_end   = out_valid && (rd_ptr == PTR_LAST);
    wr_fire     = enable && in_ready;
    wr_last     = wr_fire && (wr_ptr == PTR_LAST);
    rd_fire     = out_valid && out_ready;
    rd_last     = rd_fire && (rd_ptr == PTR_LAST);
    // Look ahead at a block completing this cycle so streaming starts one
    // cycle after its last pixel is written, and back-to-back blocks have no bubble.
    rd_bank_ready    = full_q[rd_bank]  || (wr_last && (wr_bank == rd_bank));
    other_bank_ready = full_q[~rd_bank] || (wr_last && (wr_bank != rd_bank));
  end

  // Next value of the bank-full flags: the writer sets, the reader clears.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' so later statements see the
    // updated value; clocked blocks use '<=' so all registers update together.
    full_d = full_q;
    if (rd_last) full_d[rd_bank] = 1'b0;
    if (wr_last) full_d[wr_bank] = 1'b1;
  end

  // Pixel storage, written with the level-shifted sample.
  // NOTE: the buffer array has no reset; its contents are only read after being
  // written, and leaving it unreset lets it map onto RAM.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_bank][wr_ptr] <= data_in ^ LVL_SHIFT;
  end

  // Write pointer, write bank, full flags and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      wr_bank  <= 1'b0;
      full_q   <= '0;
      overflow <= 1'b0;
    end else begin
      full_q <= full_d;
      if (wr_fire) begin
        wr_ptr <= wr_ptr + PTR_ONE;
        if (wr_last) wr_bank <= ~wr_bank;
      end else if (enable) begin
        overflow <= 1'b1;
      end
    end
  end

  // Read FSM next-state logic.
  always_comb begin
    // NOTE: assign every output of a combinational block a default first, so
    // no path leaves it unassigned and no latch is inferred.
    state_d = state_q;
    case (state_q)
      RD_IDLE:   if (rd_bank_ready) state_d = RD_STREAM;
      RD_STREAM: if (rd_last && !other_bank_ready) state_d = RD_IDLE;
      default:   state_d = RD_IDLE;
    endcase
  end

  // Read FSM state, read pointer, read bank and completed-block counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RD_IDLE;
      rd_ptr      <= '0;
      rd_bank     <= 1'b0;
      block_count <= '0;
    end else begin
      state_q <= state_d;
      if (rd_fire) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        if (rd_last) begin
          rd_bank     <= ~rd_bank;
          block_count <= block_count + CNT_ONE;
        end
      end
    end
  end

  // A bank is never completed by the writer while the reader is freeing it.
  a_no_full_conflict: assert property (@(posedge clk) disable iff (!rst_n)
    !(wr_last && rd_last && (wr_bank == rd_bank)));

endmodule

// File: tb/tb_ycbcr_block_buffer.sv
// Self-checking bench for ycbcr_block_buffer: directed scenarios plus random
// traffic, compared every cycle against a block-occupancy queue model.
module tb_ycbcr_block_buffer;

  localparam int NPIX = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable;
  logic [23:0] data_in;
  logic        in_ready;
  logic        overflow;
  logic        out_ready;
  logic        out_valid;
  logic [23:0] data_out;
  logic        block_start;
  logic        block_end;
  logic [15:0] block_count;

  ycbcr_block_buffer #(.BLOCK_PIXELS(NPIX), .CNT_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .data_in     (data_in),
    .in_ready    (in_ready),
    .overflow    (overflow),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .data_out    (data_out),
    .block_start (block_start),
    .block_end   (block_end),
    .block_count (block_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: accepted pixels in arrival order, number of complete
  // blocks held (at most two), and position within the blocks in flight.
  logic [23:0] exp_q[$];
  int          m_full   = 0;
  int          m_wr_cnt = 0;
  int          m_rd_idx = 0;
  int          m_blocks = 0;
  bit          m_ovf    = 0;
  int          cyc      = 0;

  typedef struct {
    int          c;
    bit          s;
    bit          e;
    logic [23:0] d;
  } cap_t;
  cap_t cap_q[$];

  function automatic logic [23:0] shift_pix(input logic [23:0] p);
    logic [7:0] cr, cb, y;
    cr = p[23:16] - 8'd128;
    cb = p[15:8]  - 8'd128;
    y  = p[7:0]   - 8'd128;
    return {cr, cb, y};
  endfunction

  // Compare and model-advance process: outputs are checked at the falling
  // edge, then the model consumes the inputs the next rising edge will see.
  initial begin
    bit acc_in, acc_out;
    cap_t cp;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        exp_q.delete();
        m_full = 0; m_wr_cnt = 0; m_rd_idx = 0; m_blocks = 0; m_ovf = 0;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_data_out", data_out, 0);
        check("rst_block_start", block_start, 0);
        check("rst_block_end", block_end, 0);
        check("rst_overflow", overflow, 0);
        check("rst_block_count", block_count, 0);
      end else begin
        check("in_ready", in_ready, m_full < 2);
        check("out_valid", out_valid, m_full > 0);
        check("overflow", overflow, m_ovf);
        check("block_count", block_count, m_blocks % 65536);
        if (m_full > 0) begin
          check("data_out", data_out, exp_q[0]);
          check("block_start", block_start, m_rd_idx == 0);
          check("block_end", block_end, m_rd_idx == NPIX - 1);
        end
        if (out_valid && out_ready) begin
          cp.c = cyc; cp.s = block_start; cp.e = block_end; cp.d = data_out;
          cap_q.push_back(cp);
        end
        acc_in  = (m_full < 2);
        acc_out = (m_full > 0) && out_ready;
        if (acc_out) begin
          void'(exp_q.pop_front());
          m_rd_idx++;
          if (m_rd_idx == NPIX) begin
            m_rd_idx = 0;
            m_full--;
            m_blocks++;
          end
        end
        if (enable) begin
          if (acc_in) begin
            exp_q.push_back(shift_pix(data_in));
            m_wr_cnt++;
            if (m_wr_cnt == NPIX) begin
              m_wr_cnt = 0;
              m_full++;
            end
          end else begin
            m_ovf = 1;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    enable = 1'b0;
    rst_n  = 1'b0;
    tick();
    tick();
    rst_n  = 1'b1;
  endtask

  task automatic drain(input int max_cyc);
    int k;
    k = 0;
    enable    = 1'b0;
    out_ready = 1'b1;
    while ((m_full > 0 || out_valid) && k < max_cyc) begin
      tick();
      k++;
    end
    check("drain_timeout", k < max_cyc, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    enable = 1'b0; data_in = '0; out_ready = 1'b0;
    #1 rst_n = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b1;

    // Ramp block: Y = index, Cb = 128, Cr = 255; check latency and literals.
    cap_q.delete();
    out_ready = 1'b1;
    for (int i = 0; i < NPIX; i++) begin
      enable  = 1'b1;
      data_in = {8'd255, 8'd128, 8'(i)};
      if (i == NPIX - 1) check("lat_before_last", out_valid, 0);
      tick();
    end
    enable = 1'b0;
    check("lat_first_valid", out_valid, 1);
    check("lat_first_start", block_start, 1);
    check("first_pixel_lit", data_out, 24'h7F0080);
    drain(200);
    check("ramp_count", block_count, 1);
    check("ramp_size", cap_q.size(), NPIX);
    if (cap_q.size() == NPIX) begin
      check("last_pixel_lit", cap_q[NPIX-1].d, 24'h7F00BF);
      check("last_pixel_end", cap_q[NPIX-1].e, 1);
    end

    // Boundary components {255,0,128}.
    cap_q.delete();
    for (int i = 0; i < NPIX; i++) begin
      enable  = 1'b1;
      data_in = (i == 0) ? 24'hFF0080 : 24'($urandom);
      tick();
    end
    drain(200);
    if (cap_q.size() > 0) check("boundary_lit", cap_q[0].d, 24'h7F8000);
    else check("boundary_size", 0, 1);

    // Both banks fill with the reader stalled; the 129th pixel is dropped.
    do_reset();
    cap_q.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 2 * NPIX; i++) begin
      enable  = 1'b1;
      data_in = 24'($urandom);
      tick();
    end
    check("full_in_ready", in_ready, 0);
    check("ovf_before_drop", overflow, 0);
    data_in = 24'hABCDEF;
    tick();
    enable = 1'b0;
    check("ovf_after_drop", overflow, 1);
    drain(400);
    check("ovf_sticky", overflow, 1);
    check("ovf_count", block_count, 2);
    check("ovf_size", cap_q.size(), 2 * NPIX);

    // Asynchronous reset at pixel 40 of block 1 while block 0 streams.
    out_ready = 1'b1;
    for (int i = 0; i < NPIX + 40; i++) begin
      enable  = 1'b1;
      data_in = 24'($urandom);
      tick();
    end
    enable = 1'b0;
    check("pre_rst_streaming", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_out_valid", out_valid, 0);
    check("async_count", block_count, 0);
    check("async_overflow", overflow, 0);
    check("async_in_ready", in_ready, 1);
    check("async_data_out", data_out, 0);
    tick();
    rst_n = 1'b1;
    cap_q.delete();
    for (int i = 0; i < NPIX; i++) begin
      enable  = 1'b1;
      data_in = 24'($urandom);
      tick();
    end
    drain(200);
    check("post_rst_count", block_count, 1);
    check("post_rst_size", cap_q.size(), NPIX);

    // 256 pixels at half rate with out_ready toggling: no drops.
    do_reset();
    cap_q.delete();
    for (int i = 0; i < 8 * NPIX; i++) begin
      out_ready = (i % 2 == 0);
      enable    = (i % 2 == 0);
      data_in   = 24'($urandom);
      tick();
    end
    drain(400);
    check("toggle_no_ovf", overflow, 0);
    check("toggle_count", block_count, 4);
    check("toggle_size", cap_q.size(), 4 * NPIX);

    // Back-to-back blocks with out_ready=1: no bubble between blocks.
    do_reset();
    cap_q.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 2 * NPIX; i++) begin
      enable  = 1'b1;
      data_in = 24'($urandom);
      tick();
    end
    drain(400);
    check("b2b_size", cap_q.size(), 2 * NPIX);
    if (cap_q.size() == 2 * NPIX) begin
      check("b2b_end0", cap_q[NPIX-1].e, 1);
      check("b2b_start1", cap_q[NPIX].s, 1);
      check("b2b_gap", cap_q[NPIX].c - cap_q[NPIX-1].c, 1);
    end

    // Random traffic on both sides.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      enable    = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      data_in   = 24'($urandom);
      tick();
    end
    drain(400);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
